// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI-style burst RAM slave with independent INCR write/read engines.
// Optional sticky WR_DATA_LAST protocol checker on ERR when AXI_SLAVE_ERR_EN is defined.
module axi_slave_ram #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] WR_ADDR,
    input  logic [7:0]  WR_LEN,
    input  logic [1:0]  WR_ID,
    input  logic        WR_ADDR_VALID,
    output logic        WR_ADDR_READY,
    input  logic [31:0] WR_DATA,
    input  logic [3:0]  WR_STRB,
    output logic [1:0]  WR_BACK_ID,
    input  logic        WR_DATA_VALID,
    output logic        WR_DATA_READY,
    input  logic        WR_DATA_LAST,
    input  logic [31:0] RD_ADDR,
    input  logic [7:0]  RD_LEN,
    input  logic [1:0]  RD_ID,
    input  logic        RD_ADDR_VALID,
    output logic        RD_ADDR_READY,
    output logic [31:0] RD_DATA,
    output logic        RD_DATA_LAST,
    output logic [1:0]  RD_BACK_ID,
    input  logic        RD_DATA_READY,
    output logic        RD_DATA_VALID
`ifdef AXI_SLAVE_ERR_EN
    ,
    output logic        ERR
`endif
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic {
        W_IDLE,
        W_DATA
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } r_state_e;

    logic [31:0] mem_q [MEM_DEPTH];

    w_state_e    w_state_q, w_state_d;
    logic [AW-1:0] w_idx_q, w_idx_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [1:0]  w_id_q, w_id_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;

    r_state_e    r_state_q, r_state_d;
    logic [AW-1:0] r_idx_q, r_idx_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [1:0]  r_id_q, r_id_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_word;

    logic aw_hs, w_hs, w_final, ar_hs, r_hs;
    logic unused_addr;

    assign unused_addr = ^{WR_ADDR[31:AW+2], WR_ADDR[1:0],
                           RD_ADDR[31:AW+2], RD_ADDR[1:0]};

    assign aw_hs   = WR_ADDR_VALID & awready_q;
    assign w_hs    = WR_DATA_VALID & wready_q;
    assign w_final = (w_cnt_q == w_len_q);
    assign ar_hs   = RD_ADDR_VALID & arready_q;
    assign r_hs    = rvalid_q & RD_DATA_READY;
    assign rd_word = mem_q[r_idx_q];

    // Write engine next state: latch burst on address, count beats, stop on len or LAST
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_len_d   = w_len_q;
        w_id_d    = w_id_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_idx_d   = WR_ADDR[AW+1:2];
                    w_len_d   = WR_LEN;
                    w_id_d    = WR_ID;
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_idx_d = w_idx_q + 1'b1;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (w_final || WR_DATA_LAST) begin
                        w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
    end

    // Read engine next state: fetch first word, then prefetch on every handshake
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_len_d   = r_len_q;
        r_id_d    = r_id_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_idx_d   = RD_ADDR[AW+1:2];
                    r_len_d   = RD_LEN;
                    r_id_d    = RD_ID;
                    r_cnt_d   = '0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rdata_d   = rd_word;
                rvalid_d  = 1'b1;
                rlast_d   = (r_len_q == 8'd0);
                r_idx_d   = r_idx_q + 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rdata_d = rd_word;
                        r_idx_d = r_idx_q + 1'b1;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and output registers; reset idles both engines and zeroes outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_len_q   <= '0;
            w_id_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_len_q   <= '0;
            r_id_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_len_q   <= w_len_d;
            w_id_q    <= w_id_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_len_q   <= r_len_d;
            r_id_q    <= r_id_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    // Byte-masked RAM write; reads see the old word in the same cycle
    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            for (int b = 0; b < 4; b++) begin
                if (WR_STRB[b]) begin
                    mem_q[w_idx_q][8*b +: 8] <= WR_DATA[8*b +: 8];
                end
            end
        end
    end

`ifdef AXI_SLAVE_ERR_EN
    logic err_q;

    // Sticky flag: LAST asserted on the wrong beat or missing on the final one
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_hs && (WR_DATA_LAST != w_final)) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`endif

    assign WR_ADDR_READY = awready_q;
    assign WR_DATA_READY = wready_q;
    assign WR_BACK_ID    = w_id_q;
    assign RD_ADDR_READY = arready_q;
    assign RD_DATA       = rdata_q;
    assign RD_DATA_LAST  = rlast_q;
    assign RD_BACK_ID    = r_id_q;
    assign RD_DATA_VALID = rvalid_q;

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: directed bursts with hand-computed expectations.
// Covers long bursts, strobes, stalls, wrap, early LAST and mid-burst reset.
module tb_axi_slave_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] WR_ADDR;
    logic [7:0]  WR_LEN;
    logic [1:0]  WR_ID;
    logic        WR_ADDR_VALID;
    logic        WR_ADDR_READY;
    logic [31:0] WR_DATA;
    logic [3:0]  WR_STRB;
    logic [1:0]  WR_BACK_ID;
    logic        WR_DATA_VALID;
    logic        WR_DATA_READY;
    logic        WR_DATA_LAST;
    logic [31:0] RD_ADDR;
    logic [7:0]  RD_LEN;
    logic [1:0]  RD_ID;
    logic        RD_ADDR_VALID;
    logic        RD_ADDR_READY;
    logic [31:0] RD_DATA;
    logic        RD_DATA_LAST;
    logic [1:0]  RD_BACK_ID;
    logic        RD_DATA_READY;
    logic        RD_DATA_VALID;
`ifdef AXI_SLAVE_ERR_EN
    logic        ERR;
`endif

    int errs = 0;
    int checks = 0;
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rd [256];
    logic        rl [256];
    int          nrd;

    always #5 clk = ~clk;

    axi_slave_ram #(.MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID),
        .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
        .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_BACK_ID(WR_BACK_ID),
        .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
        .WR_DATA_LAST(WR_DATA_LAST),
        .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID),
        .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
        .RD_DATA(RD_DATA), .RD_DATA_LAST(RD_DATA_LAST),
        .RD_BACK_ID(RD_BACK_ID), .RD_DATA_READY(RD_DATA_READY),
        .RD_DATA_VALID(RD_DATA_VALID)
`ifdef AXI_SLAVE_ERR_EN
        , .ERR(ERR)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [40:0] outs();
        return {WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID, RD_ADDR_READY,
                RD_DATA, RD_DATA_LAST, RD_BACK_ID, RD_DATA_VALID};
    endfunction

    task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] id, input int nbeats,
                            input int last_at);
        int n;
        WR_ADDR = addr;
        WR_LEN = len;
        WR_ID = id;
        WR_ADDR_VALID = 1'b1;
        n = 0;
        while (!WR_ADDR_READY && n < 100) begin
            tick;
            n++;
        end
        if (n >= 100) check("aw_timeout", WR_ADDR_READY, 1);
        tick;
        WR_ADDR_VALID = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            WR_DATA = wd[b];
            WR_STRB = ws[b];
            WR_DATA_LAST = (b == last_at);
            WR_DATA_VALID = 1'b1;
            n = 0;
            while (!WR_DATA_READY && n < 100) begin
                tick;
                n++;
            end
            if (n >= 100) check("w_timeout", WR_DATA_READY, 1);
            if (b == 0) check("wr_back_id", WR_BACK_ID, id);
            tick;
        end
        WR_DATA_VALID = 1'b0;
        WR_DATA_LAST = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] id, input bit toggle);
        int n;
        int cyc;
        bit stalled;
        logic [34:0] prev;
        RD_ADDR = addr;
        RD_LEN = len;
        RD_ID = id;
        RD_ADDR_VALID = 1'b1;
        RD_DATA_READY = 1'b0;
        n = 0;
        while (!RD_ADDR_READY && n < 100) begin
            tick;
            n++;
        end
        if (n >= 100) check("ar_timeout", RD_ADDR_READY, 1);
        tick;
        RD_ADDR_VALID = 1'b0;
        check("rd_fetch_gap", RD_DATA_VALID, 0);
        nrd = 0;
        cyc = 0;
        stalled = 1'b0;
        prev = '0;
        while (nrd <= int'(len) && cyc < 2000) begin
            tick;
            cyc++;
            if (cyc == 1) check("rd_latency", RD_DATA_VALID, 1);
            if (RD_DATA_VALID) begin
                if (stalled) begin
                    check("rd_hold", {RD_DATA, RD_DATA_LAST, RD_BACK_ID}, prev);
                end
                RD_DATA_READY = toggle ? cyc[0] : 1'b1;
                if (RD_DATA_READY) begin
                    rd[nrd] = RD_DATA;
                    rl[nrd] = RD_DATA_LAST;
                    check("rd_back_id", RD_BACK_ID, id);
                    nrd++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev = {RD_DATA, RD_DATA_LAST, RD_BACK_ID};
                end
            end
        end
        if (cyc >= 2000) check("rd_timeout", nrd, int'(len) + 1);
        tick;
        RD_DATA_READY = 1'b0;
        check("rd_valid_drop", RD_DATA_VALID, 0);
        check("rd_ar_ready", RD_ADDR_READY, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        WR_ADDR = '0; WR_LEN = '0; WR_ID = '0; WR_ADDR_VALID = 1'b0;
        WR_DATA = '0; WR_STRB = '0; WR_DATA_VALID = 1'b0; WR_DATA_LAST = 1'b0;
        RD_ADDR = '0; RD_LEN = '0; RD_ID = '0; RD_ADDR_VALID = 1'b0;
        RD_DATA_READY = 1'b0;
        repeat (3) tick;
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        tick;
        check("aw_ready_after_rst", WR_ADDR_READY, 1);
        check("ar_ready_after_rst", RD_ADDR_READY, 1);
        check("w_ready_idle", WR_DATA_READY, 0);

        // 112-beat write then read back from 0x170
        for (int i = 0; i < 112; i++) begin
            wd[i] = i;
            ws[i] = 4'hF;
        end
        wr_burst(32'h170, 8'd111, 2'd0, 112, 111);
        check("t1_w_done", WR_DATA_READY, 0);
        check("t1_aw_back", WR_ADDR_READY, 1);
        rd_burst(32'h170, 8'd111, 2'd2, 1'b0);
        check("t1_nbeats", nrd, 112);
        for (int i = 0; i < 112; i++) begin
            check("t1_data", rd[i], i);
            check("t1_last", rl[i], (i == 111));
        end

        // strobe merge on word 0
        wd[0] = 32'h11223344;
        ws[0] = 4'hF;
        wr_burst(32'h0, 8'd0, 2'd1, 1, 0);
        wd[0] = 32'hAABBCCDD;
        ws[0] = 4'b0101;
        wr_burst(32'h0, 8'd0, 2'd1, 1, 0);
        rd_burst(32'h0, 8'd0, 2'd1, 1'b0);
        check("t2_strb", rd[0], 32'h11BB33DD);
        check("t2_last", rl[0], 1);

        // stalled read, ready toggling
        rd_burst(32'h170, 8'd7, 2'd3, 1'b1);
        check("t3_nbeats", nrd, 8);
        for (int i = 0; i < 8; i++) begin
            check("t3_data", rd[i], i);
            check("t3_last", rl[i], (i == 7));
        end

        // wrap from word 1022
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + i;
            ws[i] = 4'hF;
        end
        wr_burst(32'hFF8, 8'd3, 2'd2, 4, 3);
        rd_burst(32'hFF8, 8'd3, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) check("t4_wrap_rd", rd[i], 32'hA0 + i);
        rd_burst(32'h0, 8'd1, 2'd0, 1'b0);
        check("t4_word0", rd[0], 32'hA2);
        check("t4_word1", rd[1], 32'hA3);

        // early LAST on beat 2 of a 4-beat burst
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hE0 + i;
            ws[i] = 4'hF;
        end
        wr_burst(32'h800, 8'd3, 2'd1, 2, 1);
        check("t5_w_done", WR_DATA_READY, 0);
        check("t5_aw_back", WR_ADDR_READY, 1);
`ifdef AXI_SLAVE_ERR_EN
        check("t5_err", ERR, 1);
`endif
        rd_burst(32'h800, 8'd1, 2'd1, 1'b0);
        check("t5_d0", rd[0], 32'hE0);
        check("t5_d1", rd[1], 32'hE1);

        // reset after beat 5 of a 16-beat write
        for (int i = 0; i < 16; i++) begin
            wd[i] = 32'h5000 + i;
            ws[i] = 4'hF;
        end
        wr_burst(32'h400, 8'd15, 2'd0, 16, 15);
        for (int i = 0; i < 16; i++) wd[i] = 32'h6000 + i;
        wr_burst(32'h400, 8'd15, 2'd3, 5, 99);
        check("t6_mid_id", WR_BACK_ID, 3);
        WR_DATA = 32'h77777777;
        WR_STRB = 4'hF;
        WR_DATA_VALID = 1'b1;
        rst = 1'b1;
        tick;
        check("t6_rst_outs", outs(), 0);
`ifdef AXI_SLAVE_ERR_EN
        check("t6_err_clr", ERR, 0);
`endif
        WR_DATA_VALID = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        check("t6_aw_ready", WR_ADDR_READY, 1);
        rd_burst(32'h400, 8'd15, 2'd2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("t6_data", rd[i], (i < 5) ? 32'h6000 + i : 32'h5000 + i);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
